// File: rtl/mvau_defn.sv
// Shared types and width helpers for the MVU processing-element accumulation path.
package mvau_defn;

    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } acc_state_t;

    // Fold counter width; a single-fold row still needs one bit for the address port.
    function automatic int sf_width(input int sf);
        return (sf > 1) ? $clog2(sf) : 1;
    endfunction

endpackage

// File: rtl/mvu_pe_acc_ctrl_if.sv
// Partial-sum input and row-result output handshake bundle of one PE accumulator.
interface mvu_pe_acc_ctrl_if #(
    parameter int TDstI = 4,
    parameter int TA    = 8,
    parameter int SF_W  = 2
);
    logic             in_v;
    logic             in_rdy;
    logic [TDstI-1:0] in_add;
    logic [SF_W-1:0]  sf_cnt;
    logic             out_v;
    logic             out_rdy;
    logic [TA-1:0]    out_acc;

    modport master (
        output in_v, in_add, out_rdy,
        input  in_rdy, sf_cnt, out_v, out_acc
    );

    modport slave (
        input  in_v, in_add, out_rdy,
        output in_rdy, sf_cnt, out_v, out_acc
    );
endinterface

// File: rtl/mvu_pe_acc_add.sv
// Combinational fold adder: restart on fold 0, else acc + zero-extended partial sum.
// MVU_PE_ACC_SAT_EN clamps the sum at all-ones instead of wrapping.
module mvu_pe_acc_add #(
    parameter int TDstI = 4,
    parameter int TA    = 8
) (
    input  logic             first,
    input  logic [TA-1:0]    acc,
    input  logic [TDstI-1:0] add,
    output logic [TA-1:0]    sum
);
    logic [TA-1:0] base;
    logic [TA-1:0] add_ext;

    assign base    = first ? '0 : acc;
    assign add_ext = TA'(add);

`ifdef MVU_PE_ACC_SAT_EN
    logic [TA:0] wide;

    // Once clamped, every later add carries out again, so saturation holds for the row.
    assign wide = {1'b0, base} + {1'b0, add_ext};
    assign sum  = wide[TA] ? {TA{1'b1}} : wide[TA-1:0];
`else
    assign sum = base + add_ext;
`endif
endmodule

// File: rtl/mvu_pe_acc_ctrl.sv
// Sequences SF partial sums per row into a TA-bit result; result registered, out_v one cycle after last beat.
// Backpressure: in_rdy drops while a result waits on out_rdy=0. Optional MVU_PE_ACC_SAT_EN saturates.
module mvu_pe_acc_ctrl
    import mvau_defn::*;
#(
    parameter int SF    = 4,
    parameter int TDstI = 4,
    parameter int TA    = 8
) (
    input  logic              aclk,
    input  logic              areset,
    mvu_pe_acc_ctrl_if.slave  bus
);
    localparam int SF_W = sf_width(SF);

    acc_state_t      state;
    logic [TA-1:0]   acc;
    logic [TA-1:0]   acc_next;
    logic [TA-1:0]   out_acc_q;
    logic [SF_W-1:0] cnt;
    logic            out_v_q;
    logic            in_rdy;
    logic            accept;
    logic            first;
    logic            last;

    assign in_rdy = ~areset & ((state == S_ACC) | bus.out_rdy);
    assign accept = bus.in_v & in_rdy;
    assign first  = (cnt == '0);
    assign last   = (cnt == SF_W'(SF - 1));

    mvu_pe_acc_add #(
        .TDstI (TDstI),
        .TA    (TA)
    ) u_add (
        .first (first),
        .acc   (acc),
        .add   (bus.in_add),
        .sum   (acc_next)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= S_ACC;
            cnt       <= '0;
            acc       <= '0;
            out_acc_q <= '0;
            out_v_q   <= 1'b0;
        end else begin
            case (state)
                S_ACC: begin
                    if (accept) begin
                        if (last) begin
                            out_acc_q <= acc_next;
                            cnt       <= '0;
                            state     <= S_OUT;
                            out_v_q   <= 1'b1;
                        end else begin
                            acc <= acc_next;
                            cnt <= cnt + SF_W'(1);
                        end
                    end
                end
                S_OUT: begin
                    // accept implies out_rdy here, so the pending result always drains first.
                    if (accept && last) begin
                        out_acc_q <= acc_next;
                        cnt       <= '0;
                    end else if (accept) begin
                        acc     <= acc_next;
                        cnt     <= cnt + SF_W'(1);
                        state   <= S_ACC;
                        out_v_q <= 1'b0;
                    end else if (bus.out_rdy) begin
                        state   <= S_ACC;
                        out_v_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_ACC;
                    out_v_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_rdy  = in_rdy;
    assign bus.sf_cnt  = cnt;
    assign bus.out_v   = out_v_q;
    assign bus.out_acc = out_acc_q;
endmodule
